// File: rtl/sram_array_1p_init_if.sv
// Request/response bus of the self-clearing single-port SRAM array.
// The requester side uses the master modport and the array uses the slave modport.
interface sram_array_1p_init_if #(
    parameter int DEPTH     = 32,
    parameter int WIDTH     = 228,
    parameter int MASK_SEGS = 2
);
    localparam int AW = $clog2(DEPTH);

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [AW-1:0]        req_addr;
    logic [MASK_SEGS-1:0] req_wmask;
    logic [WIDTH-1:0]     req_wdata;
    logic                 resp_valid;
    logic [WIDTH-1:0]     resp_rdata;
    logic                 init_done;

    modport master (
        output req_valid, req_write, req_addr, req_wmask, req_wdata,
        input  req_ready, resp_valid, resp_rdata, init_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wmask, req_wdata,
        output req_ready, resp_valid, resp_rdata, init_done
    );
endinterface

// File: rtl/sram_array_1p_init.sv
// Single-port SRAM array with a segment write mask and a clear-on-reset
// sequence.  After reset the array zeroes one entry per cycle and accepts
// no requests until every entry has been cleared.
// Optional macro SRAM_GARBAGE_EN: resp_rdata shows LFSR noise whenever
// resp_valid is low, instead of holding the last read data.
//
// state | meaning
// INIT  | clearing entry cnt_q, requests ignored
// READY | accepting one read or write per cycle
module sram_array_1p_init #(
    parameter int DEPTH     = 32,
    parameter int WIDTH     = 228,
    parameter int MASK_SEGS = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    sram_array_1p_init_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int SEG_W = WIDTH / MASK_SEGS;

    // Reject parameter sets the segment mask or address decode cannot represent.
    generate
        if ((WIDTH % MASK_SEGS) != 0) begin : g_bad_mask
            $error("sram_array_1p_init: WIDTH must be a multiple of MASK_SEGS");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sram_array_1p_init: DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             ready;
    logic             clr_we;
    logic             rd_fire;
    logic             wr_fire;
    logic             resp_valid_q;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // State register and clear counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: step through every entry once, then open for requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) begin
                state_d = ST_READY;
            end
        end
    end

    // FSM outputs: ready flag and clear write enable.
    always_comb begin
        ready  = (state_q == ST_READY);
        clr_we = (state_q == ST_INIT) && !reset;
    end

    assign rd_fire = bus.req_valid && ready && !bus.req_write && !reset;
    assign wr_fire = bus.req_valid && ready &&  bus.req_write && !reset;

    assign bus.req_ready = ready;
    assign bus.init_done = ready;

    // Storage: the clear sequence owns the port during INIT, requests afterwards.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < MASK_SEGS; i++) begin
                if (bus.req_wmask[i]) begin
                    mem_q[bus.req_addr][i*SEG_W +: SEG_W] <= bus.req_wdata[i*SEG_W +: SEG_W];
                end
            end
        end
    end

    // Read response: one-cycle pulse, data register held between reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            resp_valid_q <= rd_fire;
            if (rd_fire) begin
                rdata_q <= mem_q[bus.req_addr];
            end
        end
    end

    assign bus.resp_valid = resp_valid_q;

`ifdef SRAM_GARBAGE_EN
    logic [31:0]      lfsr_q;
    logic [31:0]      lfsr_d;
    logic [WIDTH-1:0] garbage;

    // Galois step for x^32+x^22+x^2+x+1, shifting toward bit 0.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0000_0000);
    end

    // Noise generator free-runs every cycle from a fixed seed.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= 32'hACE1_ACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Replicate the 32-bit noise word across the full data width.
    always_comb begin
        garbage = '0;
        for (int i = 0; i < WIDTH; i++) begin
            garbage[i] = lfsr_q[5'(i % 32)];
        end
    end

    assign bus.resp_rdata = resp_valid_q ? rdata_q : garbage;
`else
    assign bus.resp_rdata = rdata_q;
`endif

endmodule
